// File: rtl/key_event_reader.sv
// key_event_reader: synchronise and debounce 4 active-low buttons, turn level changes into
// press/long/release events, and deliver them one at a time over a valid/ready port.
module key_event_reader #(
    parameter int unsigned DEB_CYC  = 1_000_000,
    parameter int unsigned LONG_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] key_n,
    output logic [3:0] key_level,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_key,
    output logic [1:0] evt_type,
    output logic       evt_drop
);
    logic [3:0]  sync1_q, sync2_q, level_q, prev_q, s;
    logic [31:0] deb_q [4];
    logic [31:0] hold_q [4];
    logic [11:0] pend_q, pend_d, ev, take;
    logic        valid_q, drop_q, load;
    logic [1:0]  key_q, type_q, key_d, type_d;
    logic [3:0]  idx, rem;

    assign s = ~sync2_q;

    // Pending bit k*3+t, t: 0 press, 1 long, 2 release; lowest index wins.
    always_comb begin
        ev = '0;
        for (int k = 0; k < 4; k++) begin
            ev[3*k]   = level_q[k] & ~prev_q[k];
            ev[3*k+1] = level_q[k] && hold_q[k] == 32'(LONG_CYC - 1);
            ev[3*k+2] = ~level_q[k] & prev_q[k];
        end
        idx = '0;
        for (int i = 11; i >= 0; i--)
            if (pend_q[i]) idx = 4'(i);
        load   = (!valid_q || evt_ready) && |pend_q;
        take   = load ? 12'd1 << idx : 12'd0;
        pend_d = (pend_q & ~take) | ev;
        key_d  = 2'(idx / 4'd3);
        rem    = idx % 4'd3;
        type_d = rem == 4'd0 ? 2'b01 : rem == 4'd1 ? 2'b11 : 2'b10;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            level_q <= '0;
            prev_q  <= '0;
            for (int k = 0; k < 4; k++) begin
                deb_q[k]  <= '0;
                hold_q[k] <= '0;
            end
            pend_q  <= '0;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            key_q   <= '0;
            type_q  <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            prev_q  <= level_q;
            for (int k = 0; k < 4; k++) begin
                if (s[k] == level_q[k])
                    deb_q[k] <= '0;
                else if (deb_q[k] == 32'(DEB_CYC - 1)) begin
                    level_q[k] <= s[k];
                    deb_q[k]   <= '0;
                end else
                    deb_q[k] <= deb_q[k] + 32'd1;
                // Saturating one past the terminal count keeps the long event single-shot.
                if (!level_q[k])
                    hold_q[k] <= '0;
                else if (hold_q[k] != 32'(LONG_CYC))
                    hold_q[k] <= hold_q[k] + 32'd1;
            end
            pend_q <= pend_d;
            drop_q <= |(ev & pend_q & ~take);
            if (load) begin
                valid_q <= 1'b1;
                key_q   <= key_d;
                type_q  <= type_d;
            end else if (evt_ready)
                valid_q <= 1'b0;
        end
    end

    assign key_level = level_q;
    assign evt_valid = valid_q;
    assign evt_key   = key_q;
    assign evt_type  = type_q;
    assign evt_drop  = drop_q;
endmodule
